ysyx_220066_lsu: RTL and testbench
==================================

# ysyx_220066_lsu

Multi-cycle load/store unit between the ysyx_220066 CPU core and the 64-bit data memory port. It accepts one load or store request at a time over a valid/ready handshake. For each request it:
- checks alignment,
- drives an 8-byte-aligned bus transaction with byte write mask and replicated write data,
- waits for the memory acknowledge,
- returns sign- or zero-extended load data on a registered response channel.

It replaces the combinational read/write formatting path so that memory can have variable latency.

## Interface
Parameters:
- none

Ports:
- clk  in  1  single clock; all state updates on rising edge
- rst  in  1  reset, asynchronous, active-high
- req_valid  in  1  CPU request present
- req_ready  out  1  LSU can accept a request (high only in IDLE)
- req_wr  in  1  1 = store, 0 = load
- req_op  in  3  MemOp: 000 b, 001 h, 010 w, 011 d (signed loads); 100 bu, 101 hu, 110 wu; 111 illegal
- req_addr  in  64  byte address
- req_wdata  in  64  store data, low bytes significant
- resp_valid  out  1  response present
- resp_ready  in  1  CPU consumes response
- resp_rdata  out  64  extended load data; 0 for stores and errors
- resp_err  out  1  misaligned or illegal request; no memory access made
- mem_req  out  1  bus transaction active
- mem_we  out  1  transaction is a write
- mem_addr  out  64  {req_addr[63:3],3'b000}
- mem_wdata  out  64  replicated store data
- mem_wmask  out  8  byte enables, bit k = byte k
- mem_ack  in  1  memory completes transaction this cycle; mem_rdata valid with it
- mem_rdata  in  64  aligned 8-byte read data

## Operation
- FSM states: IDLE, BUS, RESP. Reset state is IDLE.
- IDLE: req_ready=1. On req_valid, latch the request.
  - Illegal request goes to RESP with err=1. Illegal means:
    - op=111;
    - store with op[2]=1;
    - h with addr[0]=1;
    - w/wu with addr[1:0]!=0;
    - d with addr[2:0]!=0.
  - Otherwise go to BUS.
- BUS: mem_req=1; mem_addr, mem_we, mem_wdata and mem_wmask stay stable from registers. On mem_ack, go to RESP.
  - Loads also capture the formatted data on the mem_ack edge.
  - Stores need no data capture.
- RESP: resp_valid=1 and resp_rdata/resp_err held stable. On resp_ready, go to IDLE.
- Load formatting, with o = addr[2:0]:
  - b = byte o;
  - h = bytes o..o+1;
  - w = bytes o..o+3 (o is 0 or 4);
  - d = all 8 bytes;
  - signed ops sign-extend from the top bit; unsigned ops zero-extend.
- Store formatting:
  - b: wdata = {8{wdata[7:0]}}, wmask = 8'b1<<o;
  - h: {4{wdata[15:0]}}, 8'b11<<o;
  - w: {2{wdata[31:0]}}, 8'hF<<o;
  - d: wdata, 8'hFF.
- mem_wmask=0 and mem_we=0 for loads.
- One outstanding request only. No new request is accepted until the response handshake completes.

## Timing
- Reset values:
  - req_ready=0 while rst is high, and 1 from the first cycle after deassertion;
  - resp_valid=0, resp_err=0, resp_rdata=0;
  - mem_req=0, mem_we=0, mem_addr=0, mem_wdata=0, mem_wmask=0.
- Accept edge = T0.
  - mem_req is high from T0 until the edge on which mem_ack is sampled.
  - With ack in the first BUS cycle, resp_valid rises after edge T1. This is the minimum 2-cycle latency.
- Error path: resp_valid rises after T0 (1 cycle). mem_req never asserts.
- mem_ack outside BUS is ignored.
- resp_valid with resp_ready already high costs one cycle in RESP. A new request can be accepted on the cycle after the response handshake.
- rst asserted mid-transaction: all outputs drop immediately (asynchronous), the FSM returns to IDLE, and the pending transaction is abandoned. Memory must tolerate a dropped mem_req.
- Request inputs are sampled only on the accept edge. Later changes have no effect.

## Test plan
- Load lb:
  - stimulus: addr=0x80000005, op=000, mem_rdata=0x0011_8000_0000_0000, ack in the first BUS cycle;
  - response: mem_addr=0x80000000, mem_wmask=0, resp_rdata=0xFFFF_FFFF_FFFF_FF80, resp_err=0, resp_valid 2 cycles after accept.
- Load lwu:
  - stimulus: addr=0x80000004, op=110, mem_rdata=0x8765_4321_xxxx_xxxx, ack delayed 3 cycles;
  - response: mem_req held 3 cycles with stable address, resp_rdata=0x0000_0000_8765_4321.
- Store sh:
  - stimulus: addr=0x80000006, op=001, wdata=0xABCD;
  - response: mem_we=1, mem_wmask=0xC0, mem_wdata=0xABCD_ABCD_ABCD_ABCD, resp_rdata=0.
- Misaligned sd:
  - stimulus: addr=0x80000004, op=011;
  - response: mem_req stays 0, resp_err=1 one cycle after accept.
- Store with op=100:
  - response: resp_err=1, no bus activity.
- Backpressure and reset:
  - resp_ready held low 4 cycles: resp_valid and resp_rdata stable, req_ready=0 throughout.
  - rst pulsed during BUS: mem_req falls without a clock edge, then req_ready=1 after rst release.

Source files
------------

// File: rtl/ysyx_220066_lsu.sv
// ysyx_220066_lsu: multi-cycle load/store unit between the CPU core and a 64-bit data memory port
// Ports:
//   clk, rst                 clock, asynchronous active-high reset
//   req_*                    CPU request channel (valid/ready), op, address, store data
//   resp_*                   registered response channel (valid/ready), load data, error flag
//   mem_*                    8-byte-aligned memory bus: request, write enable, address, data, mask, ack, read data
module ysyx_220066_lsu (
    input  logic        clk,
    input  logic        rst,
    input  logic        req_valid,
    output logic        req_ready,
    input  logic        req_wr,
    input  logic [2:0]  req_op,
    input  logic [63:0] req_addr,
    input  logic [63:0] req_wdata,
    output logic        resp_valid,
    input  logic        resp_ready,
    output logic [63:0] resp_rdata,
    output logic        resp_err,
    output logic        mem_req,
    output logic        mem_we,
    output logic [63:0] mem_addr,
    output logic [63:0] mem_wdata,
    output logic [7:0]  mem_wmask,
    input  logic        mem_ack,
    input  logic [63:0] mem_rdata
);
    typedef enum logic [1:0] {S_IDLE, S_BUS, S_RESP} state_t;
    state_t      r_state, w_next;
    logic        r_we, r_err;
    logic [2:0]  r_op, r_off;
    logic [63:0] r_addr, r_wdata, r_rdata;
    logic [7:0]  r_wmask;
    logic        w_acc, w_ill, w_sgn;
    logic [7:0]  w_smask;
    logic [63:0] w_swdata, w_sh, w_ld;
    assign w_acc = r_state == S_IDLE && req_valid;
    assign w_ill = req_op == 3'b111 || (req_wr && req_op[2]) ||
                   (req_op[1:0] == 2'd1 && req_addr[0]) ||
                   (req_op[1:0] == 2'd2 && req_addr[1:0] != 2'd0) ||
                   (req_op[1:0] == 2'd3 && req_addr[2:0] != 3'd0);
    assign w_smask = req_op[1:0] == 2'd0 ? 8'h01 << req_addr[2:0] :
                     req_op[1:0] == 2'd1 ? 8'h03 << req_addr[2:0] :
                     req_op[1:0] == 2'd2 ? 8'h0F << req_addr[2:0] : 8'hFF;
    assign w_swdata = req_op[1:0] == 2'd0 ? {8{req_wdata[7:0]}} :
                      req_op[1:0] == 2'd1 ? {4{req_wdata[15:0]}} :
                      req_op[1:0] == 2'd2 ? {2{req_wdata[31:0]}} : req_wdata;
    // Shift the addressed lane down to bit 0, then extend by access size.
    assign w_sh  = mem_rdata >> {r_off, 3'b000};
    assign w_sgn = !r_op[2];
    assign w_ld  = r_op[1:0] == 2'd0 ? {{56{w_sgn & w_sh[7]}}, w_sh[7:0]} :
                   r_op[1:0] == 2'd1 ? {{48{w_sgn & w_sh[15]}}, w_sh[15:0]} :
                   r_op[1:0] == 2'd2 ? {{32{w_sgn & w_sh[31]}}, w_sh[31:0]} : w_sh;
    always_ff @(posedge clk or posedge rst) begin
        if (rst) r_state <= S_IDLE;
        else r_state <= w_next;
    end
    always_comb begin
        w_next = r_state;
        case (r_state)
            S_IDLE:  w_next = !req_valid ? S_IDLE : w_ill ? S_RESP : S_BUS;
            S_BUS:   w_next = mem_ack ? S_RESP : S_BUS;
            S_RESP:  w_next = resp_ready ? S_IDLE : S_RESP;
            default: w_next = S_IDLE;
        endcase
    end
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            r_we    <= 1'b0;
            r_err   <= 1'b0;
            r_op    <= 3'd0;
            r_off   <= 3'd0;
            r_addr  <= 64'd0;
            r_wdata <= 64'd0;
            r_wmask <= 8'd0;
            r_rdata <= 64'd0;
        end else if (w_acc) begin
            r_we    <= req_wr && !w_ill;
            r_err   <= w_ill;
            r_op    <= req_op;
            r_off   <= req_addr[2:0];
            r_addr  <= {req_addr[63:3], 3'b000};
            r_wdata <= req_wr && !w_ill ? w_swdata : 64'd0;
            r_wmask <= req_wr && !w_ill ? w_smask : 8'd0;
            r_rdata <= 64'd0;
        end else if (r_state == S_BUS && mem_ack && !r_we) begin
            r_rdata <= w_ld;
        end
    end
    // rst gates req_ready so it reads 0 during reset even though the FSM already sits in IDLE.
    assign req_ready  = r_state == S_IDLE && !rst;
    assign mem_req    = r_state == S_BUS;
    assign resp_valid = r_state == S_RESP;
    assign mem_we     = r_we;
    assign mem_addr   = r_addr;
    assign mem_wdata  = r_wdata;
    assign mem_wmask  = r_wmask;
    assign resp_rdata = r_rdata;
    assign resp_err   = r_err;
endmodule

// File: tb/tb_ysyx_220066_lsu.sv
// tb_ysyx_220066_lsu: randomized self-checking bench for ysyx_220066_lsu against a byte-level memory model
module tb_ysyx_220066_lsu;
    logic        clk = 1'b0;
    logic        rst = 1'b1;
    logic        req_valid = 1'b0, req_wr = 1'b0, resp_ready = 1'b0, mem_ack = 1'b0;
    logic [2:0]  req_op = 3'd0;
    logic [63:0] req_addr = 64'd0, req_wdata = 64'd0, mem_rdata = 64'd0;
    logic        req_ready, resp_valid, resp_err, mem_req, mem_we;
    logic [63:0] resp_rdata, mem_addr, mem_wdata;
    logic [7:0]  mem_wmask;
    logic [63:0] mem [4];
    logic [63:0] got;
    int          n_chk = 0, n_err = 0;

    ysyx_220066_lsu dut (
        .clk(clk), .rst(rst),
        .req_valid(req_valid), .req_ready(req_ready), .req_wr(req_wr), .req_op(req_op),
        .req_addr(req_addr), .req_wdata(req_wdata),
        .resp_valid(resp_valid), .resp_ready(resp_ready), .resp_rdata(resp_rdata), .resp_err(resp_err),
        .mem_req(mem_req), .mem_we(mem_we), .mem_addr(mem_addr), .mem_wdata(mem_wdata),
        .mem_wmask(mem_wmask), .mem_ack(mem_ack), .mem_rdata(mem_rdata)
    );

    always #5 clk = ~clk;

    task automatic check(input string tag, input logic [63:0] obs, input logic [63:0] exp);
        n_chk++;
        if (obs !== exp) begin
            n_err++;
            $display("FAIL %s: got %h expected %h at %0t", tag, obs, exp, $time);
        end
    endtask

    function automatic int size_of(input logic [2:0] op);
        return 1 << op[1:0];
    endfunction

    function automatic logic ref_illegal(input logic wr, input logic [2:0] op, input logic [63:0] addr);
        return op == 3'b111 || (wr && op[2]) || (int'(addr[2:0]) % size_of(op) != 0);
    endfunction

    function automatic logic [63:0] ref_load(input logic [63:0] w, input logic [2:0] op, input logic [2:0] off);
        int n = size_of(op);
        logic [63:0] v = 64'd0;
        for (int i = 0; i < n; i++) v[8*i +: 8] = w[8*(int'(off) + i) +: 8];
        if (!op[2] && n < 8 && v[8*n-1]) v = v | (~64'd0 << (8*n));
        return v;
    endfunction

    function automatic logic [7:0] ref_mask(input logic [2:0] op, input logic [2:0] off);
        logic [7:0] m;
        for (int i = 0; i < 8; i++) m[i] = i >= int'(off) && i < int'(off) + size_of(op);
        return m;
    endfunction

    function automatic logic [63:0] ref_wdata(input logic [2:0] op, input logic [63:0] wd);
        logic [63:0] r;
        for (int i = 0; i < 8; i++) r[8*i +: 8] = wd[8*(i % size_of(op)) +: 8];
        return r;
    endfunction

    task automatic xfer(input logic wr, input logic [2:0] op, input logic [63:0] addr, input logic [63:0] wd,
                        input int lat, input int bp, output logic [63:0] res);
        logic        err;
        int          idx;
        logic [63:0] exp;
        logic [7:0]  m;
        err = ref_illegal(wr, op, addr);
        idx = int'(addr[4:3]);
        m   = ref_mask(op, addr[2:0]);
        exp = (err || wr) ? 64'd0 : ref_load(mem[idx], op, addr[2:0]);
        check("req_ready_idle", req_ready, 1);
        req_valid = 1; req_wr = wr; req_op = op; req_addr = addr; req_wdata = wd;
        @(posedge clk); #1;
        req_valid = 0; req_wr = 1'($urandom); req_op = 3'($urandom);
        req_addr = {$urandom, $urandom}; req_wdata = {$urandom, $urandom};
        check("req_ready_busy", req_ready, 0);
        if (err) begin
            check("err_no_memreq", mem_req, 0);
            mem_ack = 1'($urandom);
        end else begin
            check("mem_req", mem_req, 1);
            check("mem_addr", mem_addr, {addr[63:3], 3'b000});
            check("mem_we", mem_we, wr);
            check("mem_wmask", mem_wmask, wr ? m : 8'd0);
            if (wr) check("mem_wdata", mem_wdata, ref_wdata(op, wd));
            repeat (lat) begin
                check("resp_early", resp_valid, 0);
                @(posedge clk); #1;
                check("mem_req_hold", mem_req, 1);
                check("mem_addr_hold", mem_addr, {addr[63:3], 3'b000});
            end
            mem_ack = 1; mem_rdata = mem[idx];
            @(posedge clk); #1;
            mem_ack = 0; mem_rdata = {$urandom, $urandom};
            check("mem_req_drop", mem_req, 0);
            if (wr) for (int i = 0; i < 8; i++) if (m[i]) mem[idx][8*i +: 8] = ref_wdata(op, wd)[8*i +: 8];
        end
        check("resp_valid", resp_valid, 1);
        check("resp_err", resp_err, err);
        check("resp_rdata", resp_rdata, exp);
        res = resp_rdata;
        repeat (bp) begin
            @(posedge clk); #1;
            check("bp_valid", resp_valid, 1);
            check("bp_rdata", resp_rdata, exp);
            check("bp_req_ready", req_ready, 0);
        end
        mem_ack = 0;
        resp_ready = 1;
        @(posedge clk); #1;
        resp_ready = 0;
        check("resp_done", resp_valid, 0);
        check("ready_again", req_ready, 1);
    endtask

    initial begin
        #2;
        check("rst_req_ready", req_ready, 0);
        check("rst_resp_valid", resp_valid, 0);
        check("rst_resp_err", resp_err, 0);
        check("rst_resp_rdata", resp_rdata, 0);
        check("rst_mem_req", mem_req, 0);
        check("rst_mem_we", mem_we, 0);
        check("rst_mem_addr", mem_addr, 0);
        check("rst_mem_wdata", mem_wdata, 0);
        check("rst_mem_wmask", mem_wmask, 0);
        repeat (2) @(posedge clk);
        #1 rst = 0;
        @(posedge clk); #1;
        check("post_rst_ready", req_ready, 1);
        mem_ack = 1;
        @(posedge clk); #1;
        mem_ack = 0;
        check("idle_ack_ignored", resp_valid, 0);
        for (int i = 0; i < 4; i++) mem[i] = {$urandom, $urandom};

        mem[0] = 64'h0011_8000_0000_0000;
        xfer(0, 3'b000, 64'h8000_0005, 0, 0, 0, got);
        check("lb_value", got, 64'hFFFF_FFFF_FFFF_FF80);
        mem[0] = 64'h8765_4321_DEAD_BEEF;
        xfer(0, 3'b110, 64'h8000_0004, 0, 2, 0, got);
        check("lwu_value", got, 64'h0000_0000_8765_4321);
        xfer(1, 3'b001, 64'h8000_0006, 64'hABCD, 1, 0, got);
        check("sh_rdata", got, 0);
        check("sh_wmask", ref_mask(3'b001, 3'd6), 8'hC0);
        xfer(1, 3'b011, 64'h8000_0004, 64'h1234, 0, 0, got);
        xfer(1, 3'b100, 64'h8000_0000, 64'h55, 0, 0, got);
        xfer(0, 3'b111, 64'h8000_0000, 0, 0, 0, got);
        xfer(0, 3'b010, 64'h8000_0008, 0, 1, 4, got);

        for (int k = 0; k < 300; k++) begin
            logic [2:0]  op;
            logic [63:0] a;
            op = 3'($urandom_range(0, 7));
            a  = 64'h8000_0000 | 64'($urandom_range(0, 31));
            if ($urandom_range(0, 3) != 0) a = a & ~64'(size_of(op) - 1);
            xfer(1'($urandom), op, a, {$urandom, $urandom}, $urandom_range(0, 3),
                 $urandom_range(0, 4) == 0 ? $urandom_range(1, 3) : 0, got);
        end

        req_valid = 1; req_wr = 0; req_op = 3'b011; req_addr = 64'h8000_0010;
        @(posedge clk); #1;
        req_valid = 0;
        check("mid_rst_bus", mem_req, 1);
        #2 rst = 1;
        #1;
        check("mid_rst_memreq", mem_req, 0);
        check("mid_rst_ready", req_ready, 0);
        check("mid_rst_valid", resp_valid, 0);
        check("mid_rst_addr", mem_addr, 0);
        @(posedge clk); #1;
        rst = 0;
        @(posedge clk); #1;
        check("after_rst_ready", req_ready, 1);
        check("after_rst_valid", resp_valid, 0);
        xfer(0, 3'b011, 64'h8000_0018, 0, 0, 0, got);

        $display("Simulation finished: %0d checks, %0d errors", n_chk, n_err);
        $finish;
    end
endmodule
